// File: rtl/alorium_lfsr_pkg.sv
// Shared definitions for the alorium LFSR generator: burst FSM encoding,
// counter widths and the maximal-length tap table.
package alorium_lfsr_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } burst_state_t;

   localparam int unsigned STEP_CNT_W = 8;
   localparam int unsigned HB_CNT_W   = 32;

   // Maximal-length XNOR tap masks; bit i set means state bit i feeds the XNOR.
   function automatic logic [31:0] default_taps(input int unsigned width);
      case (width)
         4:       default_taps = 32'h0000_000C;
         5:       default_taps = 32'h0000_0014;
         6:       default_taps = 32'h0000_0030;
         7:       default_taps = 32'h0000_0060;
         8:       default_taps = 32'h0000_00B8;
         9:       default_taps = 32'h0000_0110;
         10:      default_taps = 32'h0000_0240;
         11:      default_taps = 32'h0000_0500;
         12:      default_taps = 32'h0000_0829;
         13:      default_taps = 32'h0000_100D;
         14:      default_taps = 32'h0000_2015;
         15:      default_taps = 32'h0000_6000;
         16:      default_taps = 32'h0000_D008;
         17:      default_taps = 32'h0001_2000;
         18:      default_taps = 32'h0002_0400;
         19:      default_taps = 32'h0004_0023;
         20:      default_taps = 32'h0009_0000;
         21:      default_taps = 32'h0014_0000;
         22:      default_taps = 32'h0030_0000;
         23:      default_taps = 32'h0042_0000;
         24:      default_taps = 32'h00E1_0000;
         25:      default_taps = 32'h0120_0000;
         26:      default_taps = 32'h0200_0023;
         27:      default_taps = 32'h0400_0013;
         28:      default_taps = 32'h0900_0000;
         29:      default_taps = 32'h1400_0000;
         30:      default_taps = 32'h2000_0029;
         31:      default_taps = 32'h4800_0000;
         32:      default_taps = 32'h8020_0003;
         default: default_taps = 32'h0000_00B8;
      endcase
   endfunction

   // The XNOR lockup state is all-ones for any width.
   function automatic logic [31:0] lockup(input int unsigned width);
      if (width >= 32)
         lockup = 32'hFFFF_FFFF;
      else
         lockup = (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/alorium_lfsr_hb.sv
// Free-running heartbeat divider with a selectable half-period.
module alorium_lfsr_hb
   import alorium_lfsr_pkg::*;
#(
   parameter int unsigned HB_DIV      = 10000000,
   parameter int unsigned HB_FAST_DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic hb_fast,
   output logic heartbeat
);

   localparam logic [HB_CNT_W-1:0] NORM_LAST = HB_CNT_W'(HB_DIV - 1);
   localparam logic [HB_CNT_W-1:0] FAST_LAST = HB_CNT_W'(HB_FAST_DIV - 1);

   logic [HB_CNT_W-1:0] r_cnt;
   logic                r_hb;
   logic [HB_CNT_W-1:0] w_last;
   logic                w_wrap;

   // '>=' rather than '==' so a switch to the fast rate never strands the count
   assign w_last = hb_fast ? FAST_LAST : NORM_LAST;
   assign w_wrap = (r_cnt >= w_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_hb  <= 1'b0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_hb  <= ~r_hb;
      end else begin
         r_cnt <= r_cnt + HB_CNT_W'(1);
      end
   end

   assign heartbeat = r_hb;

endmodule

// File: rtl/alorium_lfsr_gen.sv
// XNOR Fibonacci LFSR with run-time taps, counted bursts (busy/done),
// wrap detection against the effective seed, and a heartbeat output.
module alorium_lfsr_gen
   import alorium_lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
   parameter int unsigned      HB_DIV      = 10000000,
   parameter int unsigned      HB_FAST_DIV = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  seed_load,
   input  logic [WIDTH-1:0]      seed,
   input  logic                  taps_load,
   input  logic [WIDTH-1:0]      taps,
   input  logic                  enable,
   input  logic                  step_req,
   input  logic [STEP_CNT_W-1:0] step_cnt,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      lfsr_data,
   output logic                  data_valid,
   output logic                  wrapped,
   input  logic                  hb_fast,
   output logic                  heartbeat
);

   localparam logic [WIDTH-1:0] LOCKUP = WIDTH'(lockup(WIDTH));
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   burst_state_t          r_state;
   burst_state_t          w_state_next;
   logic [STEP_CNT_W-1:0] r_rem;
   logic                  r_busy;
   logic                  r_done;
   logic [WIDTH-1:0]      r_lfsr;
   logic [WIDTH-1:0]      r_seed;
   logic [WIDTH-1:0]      r_taps;
   logic                  r_valid;
   logic                  r_wrapped;

   logic [WIDTH-1:0]      w_tapped;
   logic [WIDTH-1:0]      w_shifted;
   logic [WIDTH-1:0]      w_seed_eff;
   logic                  w_fb;
   logic                  w_taps_accept;
   logic                  w_do_shift;
   logic                  w_load_rem;
   logic                  w_rem_dec;
   logic                  w_done_next;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
         assign w_tapped[gi] = r_lfsr[gi] & r_taps[gi];
      end
   endgenerate

   assign w_fb          = ~^w_tapped;
   assign w_shifted     = {r_lfsr[WIDTH-2:0], w_fb};
   // Never load the lockup state; substitute 1 so the sequence stays alive
   assign w_seed_eff    = (seed == LOCKUP) ? ONE : seed;
   // A zero mask would freeze the feedback, so it is simply not accepted
   assign w_taps_accept = taps_load && (taps != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (!seed_load && step_req) w_state_next = ST_RUN;
         ST_RUN:  if (seed_load || (r_rem == '0)) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // seed_load dominates everything; inside a burst, step_req and enable are ignored
   always_comb begin
      w_do_shift  = 1'b0;
      w_load_rem  = 1'b0;
      w_rem_dec   = 1'b0;
      w_done_next = 1'b0;
      if (!seed_load) begin
         case (r_state)
            ST_IDLE: begin
               if (step_req)
                  w_load_rem = 1'b1;
               else if (enable)
                  w_do_shift = 1'b1;
            end
            ST_RUN: begin
               if (r_rem != '0) begin
                  w_do_shift = 1'b1;
                  w_rem_dec  = 1'b1;
               end else begin
                  w_done_next = 1'b1;
               end
            end
            default: begin
               w_do_shift = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rem  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_next == ST_RUN);
         r_done <= w_done_next;
         if (w_load_rem)
            r_rem <= step_cnt;
         else if (w_rem_dec)
            r_rem <= r_rem - STEP_CNT_W'(1);
         else if (seed_load)
            r_rem <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr    <= ONE;
         r_seed    <= ONE;
         r_taps    <= TAPS;
         r_valid   <= 1'b0;
         r_wrapped <= 1'b0;
      end else begin
         if (seed_load) begin
            r_lfsr <= w_seed_eff;
            r_seed <= w_seed_eff;
         end else if (w_do_shift) begin
            r_lfsr <= w_shifted;
         end
         if (w_taps_accept)
            r_taps <= taps;
         r_valid   <= seed_load | w_do_shift;
         r_wrapped <= w_do_shift && (w_shifted == r_seed);
      end
   end

   alorium_lfsr_hb #(
      .HB_DIV      (HB_DIV),
      .HB_FAST_DIV (HB_FAST_DIV)
   ) u_hb (
      .clk       (clk),
      .reset     (reset),
      .hb_fast   (hb_fast),
      .heartbeat (heartbeat)
   );

   assign busy       = r_busy;
   assign done       = r_done;
   assign lfsr_data  = r_lfsr;
   assign data_valid = r_valid;
   assign wrapped    = r_wrapped;

endmodule

// File: tb/tb_alorium_lfsr_gen.sv
// Directed bench for alorium_lfsr_gen with a behavioural model checked every cycle.
module tb_alorium_lfsr_gen;

   logic       clk;
   logic       reset = 1'b1;
   logic       seed_load = 1'b0;
   logic [7:0] seed = 8'h00;
   logic       taps_load = 1'b0;
   logic [7:0] taps = 8'h00;
   logic       enable = 1'b0;
   logic       step_req = 1'b0;
   logic [7:0] step_cnt = 8'h00;
   logic       hb_fast = 1'b0;
   logic       busy, done, data_valid, wrapped, heartbeat;
   logic [7:0] lfsr_data;

   int checks = 0;
   int failures = 0;

   alorium_lfsr_gen #(
      .WIDTH(8), .TAPS(8'hB8), .HB_DIV(25), .HB_FAST_DIV(10)
   ) dut (
      .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed),
      .taps_load(taps_load), .taps(taps), .enable(enable),
      .step_req(step_req), .step_cnt(step_cnt), .busy(busy), .done(done),
      .lfsr_data(lfsr_data), .data_valid(data_valid), .wrapped(wrapped),
      .hb_fast(hb_fast), .heartbeat(heartbeat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: next state is the register shifted left with the
   // even-parity of the tapped bits appended.
   logic [7:0] m_lfsr = 8'h01, m_seed = 8'h01, m_taps = 8'hB8;
   logic       m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0, m_wrapped = 1'b0, m_hb = 1'b0;
   int         m_left = 0;
   int         m_hb_cnt = 0;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] t);
      logic fb;
      fb = (($countones(s & t) % 2) == 0);
      return {s[6:0], fb};
   endfunction

   initial begin : model_p
      logic shift;
      int   limit;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_lfsr = 8'h01; m_seed = 8'h01; m_taps = 8'hB8;
            m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_wrapped = 1'b0;
            m_hb = 1'b0; m_left = 0; m_hb_cnt = 0;
         end else begin
            shift = 1'b0; m_valid = 1'b0; m_wrapped = 1'b0; m_done = 1'b0;
            if (seed_load) begin
               m_lfsr = (seed == 8'hFF) ? 8'h01 : seed;
               m_seed = m_lfsr;
               m_valid = 1'b1;
               m_busy = 1'b0;
               m_left = 0;
            end else if (m_busy) begin
               if (m_left > 0) begin
                  shift = 1'b1;
                  m_left--;
               end else begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
            end else if (step_req) begin
               m_busy = 1'b1;
               m_left = int'(step_cnt);
            end else if (enable) begin
               shift = 1'b1;
            end
            if (shift) begin
               m_lfsr = lfsr_next(m_lfsr, m_taps);
               m_valid = 1'b1;
               m_wrapped = (m_lfsr == m_seed);
            end
            if (taps_load && taps != 8'h00) m_taps = taps;
            limit = hb_fast ? 10 : 25;
            if (m_hb_cnt >= limit - 1) begin
               m_hb_cnt = 0;
               m_hb = ~m_hb;
            end else begin
               m_hb_cnt++;
            end
         end
      end
   end

   initial begin : compare_p
      forever begin
         @(negedge clk);
         chk("cmp_lfsr_data", 32'(lfsr_data), 32'(m_lfsr));
         chk("cmp_busy", 32'(busy), 32'(m_busy));
         chk("cmp_done", 32'(done), 32'(m_done));
         chk("cmp_data_valid", 32'(data_valid), 32'(m_valid));
         chk("cmp_wrapped", 32'(wrapped), 32'(m_wrapped));
         chk("cmp_heartbeat", 32'(heartbeat), 32'(m_hb));
      end
   end

   initial begin : stim_p
      logic [7:0] exp_seq [4];
      int n, wraps, wrap_at, ff_seen, got, d;
      logic prev;

      exp_seq[0] = 8'h03; exp_seq[1] = 8'h07; exp_seq[2] = 8'h0F; exp_seq[3] = 8'h1E;

      cyc(); cyc();
      chk("reset_lfsr", 32'(lfsr_data), 32'h01);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_valid", 32'(data_valid), 32'h0);
      chk("reset_heartbeat", 32'(heartbeat), 32'h0);
      reset = 1'b0;

      // Free run from the reset state
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("run_lfsr", 32'(lfsr_data), 32'(exp_seq[i]));
         chk("run_valid", 32'(data_valid), 32'h1);
         $display("run step %0d lfsr=%02h", i + 1, lfsr_data);
      end
      chk("model_pin_1e", 32'(m_lfsr), 32'h1E);
      enable = 1'b0;

      // Seed loads, including the lockup substitution
      seed_load = 1'b1; seed = 8'hFF;
      cyc();
      chk("seed_ff_lfsr", 32'(lfsr_data), 32'h01);
      seed = 8'h5A;
      cyc();
      seed_load = 1'b0;
      chk("seed_5a_lfsr", 32'(lfsr_data), 32'h5A);
      chk("seed_5a_valid", 32'(data_valid), 32'h1);
      chk("seed_5a_wrapped", 32'(wrapped), 32'h0);
      $display("seed loads: lfsr=%02h", lfsr_data);

      // Full period from seed 01
      seed_load = 1'b1; seed = 8'h01;
      cyc();
      seed_load = 1'b0;
      enable = 1'b1;
      wraps = 0; wrap_at = 0; ff_seen = 0;
      for (int i = 1; i <= 255; i++) begin
         cyc();
         if (wrapped) begin
            wraps++;
            wrap_at = i;
         end
         if (lfsr_data == 8'hFF) ff_seen++;
      end
      enable = 1'b0;
      chk("period_wrap_count", 32'(wraps), 32'd1);
      chk("period_wrap_at", 32'(wrap_at), 32'd255);
      chk("period_end_lfsr", 32'(lfsr_data), 32'h01);
      chk("period_no_ff", 32'(ff_seen), 32'd0);
      $display("period: wraps=%0d at shift %0d", wraps, wrap_at);

      // Burst of 3 with enable held high
      step_req = 1'b1; step_cnt = 8'd3; enable = 1'b1;
      cyc();
      step_req = 1'b0;
      n = 0; got = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            got = 1;
            break;
         end
         if (busy) n++;
         cyc();
      end
      enable = 1'b0;
      chk("burst3_done_seen", 32'(got), 32'd1);
      chk("burst3_busy_cycles", 32'(n), 32'd4);
      chk("burst3_lfsr", 32'(lfsr_data), 32'h0F);
      chk("burst3_busy_low", 32'(busy), 32'h0);
      cyc();
      chk("burst3_done_one_cycle", 32'(done), 32'h0);
      $display("burst3: busy cycles=%0d lfsr=%02h", n, lfsr_data);

      // Zero-length burst
      step_req = 1'b1; step_cnt = 8'd0;
      cyc();
      step_req = 1'b0;
      chk("burst0_busy", 32'(busy), 32'h1);
      cyc();
      chk("burst0_done", 32'(done), 32'h1);
      chk("burst0_lfsr", 32'(lfsr_data), 32'h0F);
      $display("burst0: done=%0b lfsr=%02h", done, lfsr_data);

      // Burst aborted by a seed load on its third busy cycle
      step_req = 1'b1; step_cnt = 8'd10;
      cyc();
      step_req = 1'b0;
      cyc(); cyc();
      seed_load = 1'b1; seed = 8'h33;
      cyc();
      seed_load = 1'b0;
      chk("abort_lfsr", 32'(lfsr_data), 32'h33);
      chk("abort_busy", 32'(busy), 32'h0);
      d = 0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (done) d++;
      end
      chk("abort_no_done", 32'(d), 32'd0);
      $display("abort: lfsr=%02h done pulses=%0d", lfsr_data, d);

      // Fast heartbeat period
      hb_fast = 1'b1;
      prev = heartbeat; got = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (heartbeat != prev) begin
            got = 1;
            break;
         end
      end
      chk("hb_first_toggle", 32'(got), 32'd1);
      prev = heartbeat; n = 0; got = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         n++;
         if (heartbeat != prev) begin
            got = 1;
            break;
         end
      end
      chk("hb_fast_toggle_seen", 32'(got), 32'd1);
      chk("hb_fast_interval", 32'(n), 32'd10);
      $display("heartbeat fast interval=%0d", n);

      // Zero tap mask is ignored; a nonzero one takes effect
      taps_load = 1'b1; taps = 8'h00;
      cyc();
      taps_load = 1'b0;
      seed_load = 1'b1; seed = 8'h10;
      cyc();
      seed_load = 1'b0; enable = 1'b1;
      cyc();
      enable = 1'b0;
      chk("taps_zero_ignored", 32'(lfsr_data), 32'h20);
      taps_load = 1'b1; taps = 8'h8E;
      cyc();
      taps_load = 1'b0;
      seed_load = 1'b1; seed = 8'h10;
      cyc();
      seed_load = 1'b0; enable = 1'b1;
      cyc();
      enable = 1'b0;
      chk("taps_8e_applied", 32'(lfsr_data), 32'h21);
      $display("taps: lfsr after 8E shift=%02h", lfsr_data);

      // Asynchronous reset in the middle of a burst
      step_req = 1'b1; step_cnt = 8'd10;
      cyc();
      step_req = 1'b0;
      cyc(); cyc();
      #2 reset = 1'b1;
      #1;
      chk("areset_lfsr", 32'(lfsr_data), 32'h01);
      chk("areset_busy", 32'(busy), 32'h0);
      chk("areset_done", 32'(done), 32'h0);
      chk("areset_valid", 32'(data_valid), 32'h0);
      chk("areset_wrapped", 32'(wrapped), 32'h0);
      chk("areset_heartbeat", 32'(heartbeat), 32'h0);
      $display("async reset: lfsr=%02h busy=%0b", lfsr_data, busy);
      cyc(); cyc();
      reset = 1'b0;
      hb_fast = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      enable = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alorium_lfsr_gen.md
# alorium_lfsr_gen

Parametrised XNOR Fibonacci LFSR with run-time tap polynomial, counted step bursts with a busy/done handshake, sequence-wrap detection and a selectable-rate heartbeat. It is the general-purpose pseudo-random source for XLR8 peripherals. The host register interface drives it directly, and the 8-bit default build keeps the classic polynomial.

## Interface
- WIDTH, 8, LFSR width, legal 4..32
- TAPS, 8'hB8, reset tap mask (bit i set = state bit i feeds the XNOR)
- HB_DIV, 10000000, heartbeat half-period in clk cycles, normal rate
- HB_FAST_DIV, 10, heartbeat half-period in clk cycles, fast rate

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- seed_load  in  1  load seed this cycle
- seed  in  WIDTH  seed value
- taps_load  in  1  load tap mask this cycle
- taps  in  WIDTH  tap mask
- enable  in  1  free-run: one shift per cycle
- step_req  in  1  start a counted burst
- step_cnt  in  8  burst length, sampled with step_req
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- lfsr_data  out  WIDTH  current state
- data_valid  out  1  one-cycle pulse: lfsr_data changed by a shift or load
- wrapped  out  1  one-cycle pulse: a shift returned the state to the effective seed
- hb_fast  in  1  select HB_FAST_DIV
- heartbeat  out  1  square-wave heartbeat

## Operation
- Feedback: fb = ~^(lfsr_data & taps_reg). Shift: lfsr_data <= {lfsr_data[WIDTH-2:0], fb}.
- All-ones is the XNOR lockup state and is never entered.
  - seed_load with seed == all-ones loads 1 instead.
  - The loaded value becomes seed_reg, the effective seed used for wrap detection.
- taps_load with taps == 0 is ignored: taps_reg is unchanged. Otherwise taps_reg <= taps. taps_load is independent of all other controls.
- Priority per cycle: seed_load > active burst > step_req > enable.
- Burst state machine, states IDLE and RUN:
  - IDLE + step_req (no seed_load): go to RUN, rem <= step_cnt, busy <= 1.
  - RUN, rem > 0: shift, rem <= rem-1.
  - RUN, rem == 0: go to IDLE, busy <= 0, done <= 1 for one cycle. No further shift occurs.
  - step_req while busy is ignored. enable is ignored while busy.
  - seed_load while busy aborts the burst: load the seed, go to IDLE, busy <= 0, no done.
- data_valid pulses the cycle after every shift or seed load.
- wrapped pulses together with data_valid when a shift produced a value equal to seed_reg. A seed load never raises wrapped.
- Heartbeat:
  - hb_cnt is free-running and counts every cycle.
  - limit = hb_fast ? HB_FAST_DIV : HB_DIV.
  - When hb_cnt >= limit-1: hb_cnt <= 0 and heartbeat toggles.
  - A rate change with hb_cnt beyond the new limit therefore toggles on the next cycle.
- Reset values: lfsr_data = 1, seed_reg = 1, taps_reg = TAPS, state IDLE, rem = 0, busy = 0, done = 0, data_valid = 0, wrapped = 0, heartbeat = 0, hb_cnt = 0.

## Timing
- All outputs are registered. Every output is valid at the reset value immediately on reset assertion.
- Load and shift latency: 1 cycle to lfsr_data. data_valid and wrapped appear in the same cycle as the new value.
- Burst, step_req sampled at edge E0:
  - busy is high from E0.
  - Shifts occur at edges E1..EN.
  - At edge EN+1, busy falls and done pulses.
  - Total: N+1 cycles from request to done. step_cnt = 0 gives done at E1 with no shift.
- A new step_req is accepted at the edge where done is asserted.

## Structure
- Package alorium_lfsr_pkg contains:
  - the burst state encoding (IDLE, RUN)
  - the function default_taps(width) giving maximal-length masks for 4..32
  - the function lockup(width), which returns all-ones
- Sub-module alorium_lfsr_hb holds hb_cnt, the limit mux and the heartbeat flop. Its ports are clk, reset, hb_fast and heartbeat, plus the two divider parameters.

## Test plan
- Reset, then enable = 1 for 4 cycles (WIDTH = 8, TAPS = 8'hB8) -> lfsr_data steps 01, 03, 07, 0F, 1E. data_valid is high each cycle.
- seed_load with seed = FF -> lfsr_data = 01. seed_load with seed = 5A -> lfsr_data = 5A, data_valid = 1, wrapped = 0.
- Seed 01, then enable for 255 cycles -> wrapped pulses exactly once, on shift 255, with lfsr_data = 01. FF never appears.
- step_req with step_cnt = 3 from state 01 -> busy for 4 cycles, lfsr_data = 0F, then done for 1 cycle. enable held high during the burst causes no extra shifts. A repeat with step_cnt = 0 -> done after 1 cycle and lfsr_data unchanged.
- Burst with step_cnt = 10, seed_load = 33 on the 3rd busy cycle -> lfsr_data = 33, busy drops, done never pulses.
- hb_fast = 1 -> heartbeat toggles every 10 cycles. taps_load = 0 -> taps_reg unchanged. Assert reset mid-burst -> all outputs return to reset values asynchronously.
